// File: rtl/seg7_disp_sched.sv
// Round-robin scheduler sharing one serial seven-segment display
// among four requesters, with frame pacing and blink generation.
module seg7_disp_sched #(
  parameter int DWELL     = 50_000_000,
  parameter int REFRESH   = 1024,
  parameter int FLASH_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic        lock,
  input  logic [3:0]  flash_en,
  input  logic [31:0] hexs0,
  input  logic [31:0] hexs1,
  input  logic [31:0] hexs2,
  input  logic [31:0] hexs3,
  input  logic [7:0]  point0,
  input  logic [7:0]  point1,
  input  logic [7:0]  point2,
  input  logic [7:0]  point3,
  input  logic [7:0]  les0,
  input  logic [7:0]  les1,
  input  logic [7:0]  les2,
  input  logic [7:0]  les3,
  output logic        Start,
  output logic [31:0] Hexs,
  output logic [7:0]  point,
  output logic [7:0]  LES,
  output logic        flash,
  output logic [3:0]  grant,
  output logic        frame_done
);

  localparam int DW = $clog2(DWELL + 1);
  localparam int RW = $clog2(REFRESH + 1);
  localparam int FW = $clog2(FLASH_DIV + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    START,
    WAIT
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [3:0]    grant_n;
  logic [DW-1:0] dwell;
  logic [RW-1:0] rcnt;
  logic [FW-1:0] fcnt;
  logic          blink;
  logic [1:0]    ptr;
  logic          frame_end;
  logic          start_d;
  logic          rotate;
  logic [31:0]   sel_hexs;
  logic [7:0]    sel_point;
  logic [7:0]    sel_les;

  // First set request strictly after p, wrapping back to p last.
  function automatic logic [3:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [3:0] g;
    logic [1:0] idx;
    g = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = p + 2'(i);
      if (r[idx]) g = 4'b0001 << idx;
    end
    return g;
  endfunction

  function automatic logic [1:0] enc(input logic [3:0] g);
    logic [1:0] e;
    e = 2'd0;
    unique case (1'b1)
      g[0]:    e = 2'd0;
      g[1]:    e = 2'd1;
      g[2]:    e = 2'd2;
      g[3]:    e = 2'd3;
      default: e = 2'd0;
    endcase
    return e;
  endfunction

  assign frame_end = (state == WAIT) && (rcnt == '0);

  assign rotate = !(|(req & grant)) ||
                  ((dwell >= DW'(DWELL)) && !lock &&
                   (|(req & ~grant)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
    end
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = LOAD;
          grant_n = pick(req, ptr);
        end
      end
      LOAD:  state_n = START;
      START: state_n = WAIT;
      WAIT: begin
        if (frame_end) begin
          if (req == '0) begin
            state_n = IDLE;
            grant_n = '0;
          end else begin
            state_n = LOAD;
            if (rotate) grant_n = pick(req, ptr);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    start_d    = (state == START);
    frame_done = frame_end;
  end

  always_comb begin
    sel_hexs  = '0;
    sel_point = '0;
    sel_les   = '0;
    unique case (1'b1)
      grant[0]: begin
        sel_hexs  = hexs0;
        sel_point = point0;
        sel_les   = les0;
      end
      grant[1]: begin
        sel_hexs  = hexs1;
        sel_point = point1;
        sel_les   = les1;
      end
      grant[2]: begin
        sel_hexs  = hexs2;
        sel_point = point2;
        sel_les   = les2;
      end
      grant[3]: begin
        sel_hexs  = hexs3;
        sel_point = point3;
        sel_les   = les3;
      end
      default: begin
        sel_hexs  = '0;
        sel_point = '0;
        sel_les   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
      ptr   <= 2'd3;
    end else if (grant_n != grant) begin
      dwell <= '0;
      if (|grant_n) ptr <= enc(grant_n);
    end else if (dwell < DW'(DWELL)) begin
      dwell <= dwell + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt <= '0;
    end else if (state == START) begin
      rcnt <= RW'(REFRESH - 3);
    end else if (state == WAIT && rcnt != '0) begin
      rcnt <= rcnt - RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Start <= 1'b0;
      Hexs  <= '0;
      point <= '0;
      LES   <= '0;
    end else begin
      Start <= start_d;
      if (state == LOAD) begin
        Hexs  <= sel_hexs;
        point <= sel_point;
        LES   <= sel_les;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      blink <= 1'b0;
      flash <= 1'b0;
    end else begin
      if (fcnt == FW'(FLASH_DIV - 1)) begin
        fcnt  <= '0;
        blink <= ~blink;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
      flash <= blink & (|(grant & flash_en));
    end
  end

endmodule
